// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC packet arbiter: header TID, header field offsets, FSM states.
package noc_arb_pkg;

  localparam int ROUTING_HEADER = 0;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } state_t;

  // Header layout from bit 0 upward: dst_y, dst_x, src_y, src_x, then LEN.
  function automatic int hdr_x_lsb(input int yw);
    return yw;
  endfunction

  function automatic int hdr_len_lsb(input int xw, input int yw);
    return 2 * (xw + yw);
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Rotating priority pick: first requester at or after ptr, wrapping modulo N.
module noc_rr_pick #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          hit
);

  logic [PW:0] cand;

  // Scan from the far end so the candidate closest to ptr wins; wrap by subtraction so N need not be 2^k.
  always_comb begin
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (req[cand[PW-1:0]]) begin
        idx = cand[PW-1:0];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_pkt_arbiter.sv
// Packet-locked round-robin arbiter for a NoC router output port.
// Define NOC_ARB_WATCHDOG_EN to add the stall watchdog with forced release.
module noc_pkt_arbiter
  import noc_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int WDOG_CYCLES    = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata_i,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]   in_tid_i,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid_i,
  output logic [CHANNEL_NUMBER-1:0]            in_tready_o,
  output logic [DATA_WIDTH-1:0]                out_tdata_o,
  output logic [ID_WIDTH-1:0]                  out_tid_o,
  output logic                                 out_tvalid_o,
  input  logic                                 out_tready_i,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]    current_grant_o,
  output logic                                 grant_valid_o,
  output logic [$clog2(MAX_ROUTERS_X)-1:0]     target_x_o,
  output logic [$clog2(MAX_ROUTERS_Y)-1:0]     target_y_o,
  output logic                                 pkt_done_o,
  output logic                                 wdog_err_o
);

  localparam int XW      = $clog2(MAX_ROUTERS_X);
  localparam int YW      = $clog2(MAX_ROUTERS_Y);
  localparam int GW      = $clog2(CHANNEL_NUMBER);
  localparam int X_LSB   = hdr_x_lsb(YW);
  localparam int LEN_LSB = hdr_len_lsb(XW, YW);

  state_t               state, state_nxt;
  logic [GW-1:0]        grant, rr_ptr, pick_idx, grant_inc;
  logic                 pick_hit;
  logic [LEN_WIDTH-1:0] count, hdr_len;
  logic [XW-1:0]        tgt_x, hdr_x;
  logic [YW-1:0]        tgt_y, hdr_y;
  logic                 active, sel_valid, hs, is_hdr, hdr_live;
  logic                 release_pkt, done, wdog_fire;

  noc_rr_pick #(.N(CHANNEL_NUMBER), .PW(GW)) u_pick (
    .req(in_tvalid_i),
    .ptr(rr_ptr),
    .idx(pick_idx),
    .hit(pick_hit)
  );

  assign active = (state != IDLE);

  // Zero-latency crossbar from the locked channel; only that channel sees backpressure.
  always_comb begin
    out_tdata_o = '0;
    out_tid_o   = '0;
    sel_valid   = 1'b0;
    in_tready_o = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      if (grant == GW'(c)) begin
        out_tdata_o = in_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
        out_tid_o   = in_tid_i[c*ID_WIDTH +: ID_WIDTH];
        sel_valid   = in_tvalid_i[c];
        if (active) in_tready_o[c] = out_tready_i;
      end
    end
  end

  assign out_tvalid_o = active & sel_valid;
  assign hs           = out_tvalid_o & out_tready_i;
  assign is_hdr       = (out_tid_o == ID_WIDTH'(ROUTING_HEADER));
  assign hdr_len      = out_tdata_o[LEN_LSB +: LEN_WIDTH];
  assign hdr_x        = out_tdata_o[X_LSB +: XW];
  assign hdr_y        = out_tdata_o[0 +: YW];
  assign hdr_live     = (state == HEAD) && out_tvalid_o && is_hdr;
  assign grant_inc    = (grant == GW'(CHANNEL_NUMBER - 1)) ? '0 : grant + GW'(1);

  always_comb begin
    state_nxt   = state;
    done        = 1'b0;
    release_pkt = 1'b0;
    case (state)
      IDLE: if (pick_hit) state_nxt = HEAD;
      HEAD: begin
        if (hs) begin
          if (is_hdr && hdr_len != '0) begin
            state_nxt = BODY;
          end else begin
            done        = 1'b1;
            release_pkt = 1'b1;
          end
        end
      end
      BODY: begin
        if (hs && count == LEN_WIDTH'(1)) begin
          done        = 1'b1;
          release_pkt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wdog_fire) release_pkt = 1'b1;
    if (release_pkt) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      count  <= '0;
      tgt_x  <= '0;
      tgt_y  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_hit) grant <= pick_idx;
      if (state == HEAD && hs && is_hdr && hdr_len != '0) begin
        count <= hdr_len;
        tgt_x <= hdr_x;
        tgt_y <= hdr_y;
      end else if (state == BODY && hs) begin
        count <= count - LEN_WIDTH'(1);
      end
      if (release_pkt) rr_ptr <= grant_inc;
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] stall;
  logic          wdog_err;

  // Fires on the WDOG_CYCLES-th consecutive locked cycle without a handshake.
  assign wdog_fire = active && !hs && (stall == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall    <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (!active || hs) stall <= '0;
      else               stall <= stall + WW'(1);
      if (wdog_fire) wdog_err <= 1'b1;
    end
  end

  assign wdog_err_o = wdog_err;
`else
  logic [31:0] wdog_unused;
  assign wdog_unused = WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
  assign wdog_err_o  = 1'b0;
`endif

  assign current_grant_o = grant;
  assign grant_valid_o   = active;
  assign pkt_done_o      = done;
  assign target_x_o      = hdr_live ? hdr_x : tgt_x;
  assign target_y_o      = hdr_live ? hdr_y : tgt_y;

endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Scoreboard bench for noc_pkt_arbiter: per-channel source queues feed the DUT, expected flits are queued in grant order.
module tb_noc_pkt_arbiter;
  localparam int NCH = 5;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int GW  = 3;

  typedef struct { logic [DW-1:0] data; logic [IW-1:0] tid; } flit_t;
  typedef struct { int ch; logic [DW-1:0] data; logic [IW-1:0] tid; bit done; } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] in_tdata;
  logic [NCH*IW-1:0] in_tid;
  logic [NCH-1:0]    in_tvalid, in_tready;
  logic [DW-1:0]     out_tdata;
  logic [IW-1:0]     out_tid;
  logic              out_tvalid, out_tready;
  logic [GW-1:0]     current_grant;
  logic              grant_valid, pkt_done, wdog_err;
  logic [1:0]        target_x, target_y;

  flit_t          src_q [NCH][$];
  exp_t           exp_q[$];
  int             done_cyc[$];
  logic [NCH-1:0] hold, pop_mask;
  int             cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  noc_pkt_arbiter #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(NCH), .MAX_ROUTERS_X(4),
    .MAX_ROUTERS_Y(4), .LEN_WIDTH(8), .WDOG_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_tdata_i(in_tdata), .in_tid_i(in_tid),
    .in_tvalid_i(in_tvalid), .in_tready_o(in_tready), .out_tdata_o(out_tdata),
    .out_tid_o(out_tid), .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
    .current_grant_o(current_grant), .grant_valid_o(grant_valid),
    .target_x_o(target_x), .target_y_o(target_y), .pkt_done_o(pkt_done),
    .wdog_err_o(wdog_err)
  );

  function automatic logic [DW-1:0] pkt_word(input int c, input int x, input int y, input int len, input int idx);
    if (idx == 0) return (DW'(len) << 8) | (DW'(x) << 2) | DW'(y);
    return {8'hB0, 8'(c), 16'(idx)};
  endfunction

  // Source flits go to channel c when to_src; flits with index in [ef, et] go to the scoreboard.
  task automatic push_pkt(input int c, input int x, input int y, input int len,
                          input bit to_src, input int ef, input int et);
    flit_t f;
    exp_t  e;
    for (int i = 0; i <= len; i++) begin
      f.data = pkt_word(c, x, y, len, i);
      f.tid  = (i == 0) ? 4'd0 : 4'd1;
      if (to_src) src_q[c].push_back(f);
      if (i >= ef && i <= et) begin
        e.ch = c; e.data = f.data; e.tid = f.tid; e.done = (i == len);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() != 0 && !hold[c]) begin
        in_tvalid[c]         = 1'b1;
        in_tdata[c*DW +: DW] = src_q[c][0].data;
        in_tid[c*IW +: IW]   = src_q[c][0].tid;
      end else begin
        in_tvalid[c]         = 1'b0;
        in_tdata[c*DW +: DW] = '0;
        in_tid[c*IW +: IW]   = '0;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    pop_mask = in_tvalid & in_tready;
    checks++;
    if (grant_valid && current_grant >= GW'(NCH)) begin
      errors++; $display("FAIL grant_range got %0d required < %0d", current_grant, NCH);
    end
    if (out_tvalid && out_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_flit got ch%0d data %h required none", current_grant, out_tdata);
      end else begin
        e = exp_q.pop_front();
        if (current_grant !== GW'(e.ch) || out_tdata !== e.data || out_tid !== e.tid || pkt_done !== e.done) begin
          errors++;
          $display("FAIL flit got ch%0d data %h tid %0d done %b required ch%0d data %h tid %0d done %b",
                   current_grant, out_tdata, out_tid, pkt_done, e.ch, e.data, e.tid, e.done);
        end
        if (pkt_done) done_cyc.push_back(cyc);
      end
    end else begin
      checks++;
      if (pkt_done !== 1'b0) begin
        errors++; $display("FAIL done_without_handshake got %b required 0", pkt_done);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int c = 0; c < NCH; c++)
      if (pop_mask[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
    drive();
    #1;
  endtask

  task automatic run_drain(input int max, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_%s got %0d flits pending required 0", name, exp_q.size());
    end
  endtask

  task automatic flush();
    hold = '0;
    exp_q.delete();
    done_cyc.delete();
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1; out_tready = 1'b1; flush();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got %b required 0", grant_valid); end
    checks++; if (current_grant !== 3'd0) begin errors++; $display("FAIL rst_grant got %0d required 0", current_grant); end
    checks++; if (in_tready !== 5'd0 || out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_handshake got tready %b tvalid %b required 0", in_tready, out_tvalid); end
    checks++; if (target_x !== 2'd0 || target_y !== 2'd0) begin errors++; $display("FAIL rst_target got %0d,%0d required 0,0", target_x, target_y); end
    checks++; if (pkt_done !== 1'b0 || wdog_err !== 1'b0) begin errors++; $display("FAIL rst_flags got done %b wdog %b required 0", pkt_done, wdog_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    push_pkt(2, 1, 2, 3, 1, 0, 3);
    drive(); #1;
    cycle();
    checks++; if (grant_valid !== 1'b1 || current_grant !== 3'd2) begin errors++; $display("FAIL single_grant got v%b ch%0d required v1 ch2", grant_valid, current_grant); end
    checks++; if (target_x !== 2'd1 || target_y !== 2'd2) begin errors++; $display("FAIL single_hdr_decode got %0d,%0d required 1,2", target_x, target_y); end
    cycle();
    checks++; if (target_x !== 2'd1 || target_y !== 2'd2) begin errors++; $display("FAIL single_latched got %0d,%0d required 1,2", target_x, target_y); end
    run_drain(10, "single");
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b required 0", grant_valid); end
    checks++; if (dut.rr_ptr !== 3'd3) begin errors++; $display("FAIL single_rr_ptr got %0d required 3", dut.rr_ptr); end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL single_done_count got %0d required 1", done_cyc.size()); end
  endtask

  task automatic test_wrap();
    push_pkt(4, 0, 1, 0, 1, 0, 0);
    push_pkt(0, 2, 3, 0, 1, 0, 0);
    push_pkt(1, 3, 0, 0, 1, 0, 0);
    drive(); #1;
    run_drain(20, "wrap");
    checks++; if (dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL wrap_rr_ptr got %0d required 2", dut.rr_ptr); end
  endtask

  task automatic test_len0_and_malformed();
    flit_t f;
    exp_t  e;
    push_pkt(1, 2, 3, 0, 1, 0, 0);
    drive(); #1;
    cycle();
    checks++; if (grant_valid !== 1'b1 || current_grant !== 3'd1) begin errors++; $display("FAIL len0_grant got v%b ch%0d required v1 ch1", grant_valid, current_grant); end
    cycle();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL len0_no_body got %b required 0", grant_valid); end
    f.data = 32'hDEAD_0007; f.tid = 4'd5;
    src_q[0].push_back(f);
    e.ch = 0; e.data = f.data; e.tid = f.tid; e.done = 1'b1;
    exp_q.push_back(e);
    drive(); #1;
    cycle();
    checks++; if (current_grant !== 3'd0) begin errors++; $display("FAIL malformed_grant got %0d required 0", current_grant); end
    cycle();
    checks++; if (grant_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL malformed_release got v%b pending %0d required v0 pending 0", grant_valid, exp_q.size()); end
  endtask

  task automatic test_all_rr();
    rst = 1'b1; flush();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) push_pkt(c, c % 4, (c + 1) % 4, 1, 1, 0, 1);
    drive(); #1;
    run_drain(60, "all_rr");
    checks++; if (done_cyc.size() != 10) begin errors++; $display("FAIL rr_done_count got %0d required 10", done_cyc.size()); end
    for (int i = 1; i < done_cyc.size(); i++) begin
      checks++;
      if (done_cyc[i] - done_cyc[i-1] != 3) begin
        errors++; $display("FAIL rr_pkt_period got %0d required 3 (pkt %0d)", done_cyc[i] - done_cyc[i-1], i);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    rst = 1'b1; flush();
    @(posedge clk); #1;
    rst = 1'b0;
    push_pkt(3, 2, 1, 4, 1, 0, 2);
    drive(); #1;
    run_drain(10, "stall_head");
    checks++; if (dut.count !== 8'd2 || current_grant !== 3'd3) begin errors++; $display("FAIL stall_count got %0d ch%0d required 2 ch3", dut.count, current_grant); end
    hold[3] = 1'b1;
    push_pkt(0, 1, 1, 1, 1, 9, 0);
    drive(); #1;
`ifdef NOC_ARB_WATCHDOG_EN
    n = 0;
    while (!(grant_valid && current_grant == 3'd0) && n < 20) begin
      cycle();
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL wdog_release got %0d cycles required 9", n); end
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_err got %b required 1", wdog_err); end
    src_q[3].delete();
    hold[3] = 1'b0;
    push_pkt(0, 1, 1, 1, 0, 0, 1);
    drive(); #1;
    run_drain(20, "wdog_ch0");
`else
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (grant_valid !== 1'b1 || current_grant !== 3'd3 || out_tvalid !== 1'b0) begin
        errors++; $display("FAIL stall_lock got v%b ch%0d tvalid %b required v1 ch3 tvalid 0", grant_valid, current_grant, out_tvalid);
      end
    end
    hold[3] = 1'b0;
    push_pkt(3, 2, 1, 4, 0, 3, 4);
    push_pkt(0, 1, 1, 1, 0, 0, 1);
    drive(); #1;
    run_drain(20, "stall_finish");
    checks++; if (dut.rr_ptr !== 3'd1 || wdog_err !== 1'b0) begin errors++; $display("FAIL stall_after got ptr %0d wdog %b required 1 0", dut.rr_ptr, wdog_err); end
`endif
  endtask

  task automatic test_reset_mid();
    push_pkt(2, 3, 3, 3, 1, 0, 3);
    drive(); #1;
    cycle(); cycle(); cycle();
    checks++; if (grant_valid !== 1'b1 || target_x !== 2'd3) begin errors++; $display("FAIL mid_body got v%b x%0d required v1 x3", grant_valid, target_x); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant_valid !== 1'b0 || current_grant !== 3'd0) begin errors++; $display("FAIL mid_rst_lock got v%b ch%0d required v0 ch0", grant_valid, current_grant); end
    checks++; if (in_tready !== 5'd0 || out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b tvalid %b required 0", in_tready, out_tvalid); end
    checks++; if (target_x !== 2'd0 || target_y !== 2'd0) begin errors++; $display("FAIL mid_rst_target got %0d,%0d required 0,0", target_x, target_y); end
    flush();
    rst = 1'b0;
  endtask

  initial begin
    hold = '0; rst = 1'b1; out_tready = 1'b1;
    in_tdata = '0; in_tid = '0; in_tvalid = '0;
    test_reset();
    test_single();
    test_wrap();
    test_len0_and_malformed();
    test_all_rr();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion required summary");
    $fatal(1);
  end

endmodule
